shift_add_mult_ctrl: RTL
========================

// Module: shift_add_mult_ctrl
// PURPOSE
//  Sequencer for the serial shift-and-add multiplier. It loads the multiplier operand into
//  the parallel-in/serial-out right shift register and steps that register one bit per cycle.
//  For each 1 bit it adds the shifted multiplicand into a 2*WORD_LENGTH accumulator.
//  Sits between the top-level start/ready handshake and the shift register instance.
// PARAMETERS
//  WORD_LENGTH  4  operand width in bits; product is 2*WORD_LENGTH
// PORTS
//  clk           in   1       system clock, all logic on rising edge
//  reset         in   1       synchronous, active-high; sampled on rising clk edge only
//  start         in   1       request multiply; sampled only in IDLE
//  multiplicand  in   W       operand A; captured in the IDLE->LOAD cycle
//  multiplier    in   W       operand B; forwarded to the shift register in the same cycle
//  sr_data       out  W       parallel load data to the shift register (registered copy of B)
//  sr_load       out  1       one-cycle load strobe to the shift register
//  sr_shift      out  1       shift-enable to the shift register
//  sr_bit        in   1       serial bit from the shift register (current index bit)
//  product       out  2W      result; held stable from done until the next accepted start
//  ready         out  1       1 in IDLE only
//  done          out  1       one-cycle pulse when product is valid
// BEHAVIOUR
//  - Reset (reset=1 at an edge): state=IDLE; product, accumulator, counter and sr_data=0;
//    sr_load=sr_shift=done=0; ready=1 in the cycle after the reset edge.
//  - Reset mid-operation aborts immediately. No done pulse. The shift register shares reset.
//  - FSM states, one transition per clk edge:
//    IDLE : ready=1. start=1 -> capture multiplicand into mcand_r and multiplier into sr_data;
//           clear acc and cnt; go to LOAD.
//    LOAD : sr_load=1 for exactly this cycle -> RUN.
//    RUN  : sr_shift=1. acc <= acc + (sr_bit ? ({W'b0,mcand_r} << cnt) : 0); cnt <= cnt+1.
//           When cnt==W-1 -> FLUSH with cnt<=0.
//    FLUSH: sr_shift=1, no accumulation, for W cycles. This brings the register's internal
//           index back to 0; it wraps only after 2W shifts. cnt==W-1 -> DONE.
//    DONE : product <= acc; done=1 in the same cycle product updates -> IDLE.
//  - Latency: with start accepted at edge 0, LOAD occupies cycle 1, RUN cycles 2..W+1,
//    FLUSH cycles W+2..2W+1, and done=1 in cycle 2W+2 (10 for W=4).
//    Throughput is one result per 2W+3 cycles.
//  - start outside IDLE is ignored, including during DONE. Operand changes after capture
//    are ignored.
//  - Arithmetic: unsigned. acc is 2W bits wide. The maximum (2^W-1)^2 < 2^(2W), so
//    overflow cannot occur. The shifted partial product is zero-extended before the add.
//  - sr_shift is never asserted in the LOAD cycle, so load and shift never collide.
//  - cnt is $clog2(W) bits wide and wraps only through the explicit clears above.
// STRUCTURE
//  - multiplier_pkg: state encoding (IDLE, LOAD, RUN, FLUSH, DONE), CNT_W = $clog2(WORD_LENGTH),
//    and a default WORD_LENGTH constant shared with the shift register and the top level.
//  - One natural sub-module: mult_accumulator (mcand_r, acc, shifted add, product register).
//    It is controlled by add_en, clr and commit from the FSM.
//  - The FSM and cnt stay in this module. The shift register stays an external instance.
// TESTING
//  - Reset: hold reset=1 for 2 cycles -> ready=1, done=0, product=0, sr_load=sr_shift=0.
//  - 3*5, W=4: start pulse -> sr_load high in cycle 1 only, sr_shift high in cycles 2..9,
//    done in cycle 10, product=15.
//  - Max 15*15 -> product=225 (8'hE1). 0*15 and 15*0 -> product=0, and done still arrives
//    in cycle 10.
//  - Back-to-back: start held high continuously -> second op accepted in the IDLE after DONE.
//    No start is taken in LOAD/RUN/FLUSH/DONE. Results 7*9=63, then 2*8=16.
//  - Reset asserted in RUN cycle 4 -> IDLE next cycle, no done pulse, product=0.
//    Next op 6*6 -> 36.
//  - With the shift register instance attached, run 10 consecutive random ops
//    -> every product matches A*B, proving FLUSH realigns the register index.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared definitions for the serial shift-and-add multiplier: FSM encoding,
// default operand width and counter sizing.
package multiplier_pkg;

  localparam int DEF_WORD_LENGTH = 4;

  // Counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_WORD_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mult_accumulator.sv
// Datapath for the shift-and-add multiplier: multiplicand register, 2W-bit
// accumulator of shifted partial products and the committed product register.
module mult_accumulator
  import multiplier_pkg::*;
#(
  parameter  int WORD_LENGTH = DEF_WORD_LENGTH,
  localparam int CW          = cnt_width(WORD_LENGTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_clr,
  input  logic [WORD_LENGTH-1:0]     i_mcand,
  input  logic                       i_add_en,
  input  logic                       i_bit,
  input  logic [CW-1:0]              i_cnt,
  input  logic                       i_commit,
  output logic [2*WORD_LENGTH-1:0]   o_product
);

  logic [WORD_LENGTH-1:0]   r_mcand;
  logic [2*WORD_LENGTH-1:0] r_acc;
  logic [2*WORD_LENGTH-1:0] r_product;
  logic [2*WORD_LENGTH-1:0] w_partial;

  // Zero-extend before shifting so no multiplicand bit is lost.
  always_comb begin
    w_partial = '0;
    if (i_bit) w_partial = {{WORD_LENGTH{1'b0}}, r_mcand} << i_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      if (i_clr) begin
        r_mcand <= i_mcand;
        r_acc   <= '0;
      end else if (i_add_en) begin
        r_acc <= r_acc + w_partial;
      end
      if (i_commit) r_product <= r_acc;
    end
  end

  assign o_product = r_product;

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for the serial shift-and-add multiplier: drives the external
// PISO shift register and steers the accumulator datapath.
module shift_add_mult_ctrl
  import multiplier_pkg::*;
#(
  parameter  int WORD_LENGTH = DEF_WORD_LENGTH,
  localparam int CW          = cnt_width(WORD_LENGTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WORD_LENGTH-1:0]   multiplicand,
  input  logic [WORD_LENGTH-1:0]   multiplier,
  output logic [WORD_LENGTH-1:0]   sr_data,
  output logic                     sr_load,
  output logic                     sr_shift,
  input  logic                     sr_bit,
  output logic [2*WORD_LENGTH-1:0] product,
  output logic                     ready,
  output logic                     done,
  output state_t                   o_state
);

  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_LENGTH - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CW-1:0]          r_cnt;
  logic [WORD_LENGTH-1:0] r_sr_data;
  logic                   w_cnt_last;
  logic                   w_clr;
  logic                   w_add_en;
  logic                   w_commit;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_LOAD;
      S_LOAD:  w_next_state = S_RUN;
      S_RUN:   if (w_cnt_last) w_next_state = S_FLUSH;
      S_FLUSH: if (w_cnt_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Product is committed on the FLUSH->DONE edge so it is valid while done=1.
  always_comb begin
    ready    = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    done     = 1'b0;
    w_clr    = 1'b0;
    w_add_en = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        w_clr = start;
      end
      S_LOAD:  sr_load = 1'b1;
      S_RUN: begin
        sr_shift = 1'b1;
        w_add_en = 1'b1;
      end
      S_FLUSH: begin
        sr_shift = 1'b1;
        w_commit = w_cnt_last;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // RUN and FLUSH each wrap the counter explicitly after W steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_sr_data <= '0;
    end else if (w_clr) begin
      r_cnt     <= '0;
      r_sr_data <= multiplier;
    end else if (sr_shift) begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
    end
  end

  mult_accumulator #(.WORD_LENGTH(WORD_LENGTH)) u_acc (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_clr),
    .i_mcand   (multiplicand),
    .i_add_en  (w_add_en),
    .i_bit     (sr_bit),
    .i_cnt     (r_cnt),
    .i_commit  (w_commit),
    .o_product (product)
  );

  assign sr_data = r_sr_data;
  assign o_state = r_state;

endmodule
